// File: rtl/drain_pkg.sv
// Shared types and default geometry for the systolic result drain.
// Optional build macro: DRAIN_RELU_EN (clamp negative outputs to zero).
package drain_pkg;

  localparam int SIZE_D  = 16;
  localparam int ACC_W_D = 20;
  localparam int OUT_W_D = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/requant_lane.sv
// One combinational requant lane: round half up, arithmetic shift, saturate.
// With DRAIN_RELU_EN defined, negative results are clamped to zero.
module requant_lane
  import drain_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] q
);

  localparam int W = ACC_W + 1;
  localparam logic signed [W-1:0] MAXV = W'(2**(OUT_W-1) - 1);
  localparam logic signed [W-1:0] MINV = W'(-(2**(OUT_W-1)));

  logic signed [W-1:0]     rnd;
  logic signed [W-1:0]     sum;
  logic signed [W-1:0]     shd;
  logic signed [OUT_W-1:0] sat;

  always_comb begin
    rnd = '0;
    if (shift != 5'd0)
      rnd = W'(1) << (shift - 5'd1);
    // one guard bit keeps the rounding add from wrapping at full scale
    sum = W'(acc) + rnd;
    shd = sum >>> shift;
    if (shd > MAXV)
      sat = MAXV[OUT_W-1:0];
    else if (shd < MINV)
      sat = MINV[OUT_W-1:0];
    else
      sat = shd[OUT_W-1:0];
`ifdef DRAIN_RELU_EN
    q = sat[OUT_W-1] ? '0 : sat;
`else
    q = sat;
`endif
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a finished accumulator matrix and streams it out row by row.
// Optional build macro: DRAIN_RELU_EN (ReLU after saturation).
module systolic_result_drain
  import drain_pkg::*;
#(
  parameter int SIZE  = SIZE_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  localparam int RW   = $clog2(SIZE)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                done_in,
  input  logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] result_in,
  input  logic [4:0]                          shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIZE-1:0][OUT_W-1:0]          out_data,
  output logic [RW-1:0]                       out_row,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun,
  input  logic                                clear_err
);

  state_t                             state_q;
  logic [RW-1:0]                      row_q;
  logic [4:0]                         shift_q;
  logic                               overrun_q;
  logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] mat_q;
  logic [SIZE-1:0][OUT_W-1:0]         lane_q;

  logic streaming;
  logic accept;
  logic last;
  logic cap;
  logic drop;

  assign streaming = (state_q == STREAM);
  assign accept    = streaming && out_ready;
  assign last      = (row_q == RW'(SIZE - 1));
  assign cap       = done_in && (!streaming || (accept && last));
  assign drop      = done_in && streaming && !(accept && last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (drop)
        overrun_q <= 1'b1;
      else if (clear_err)
        overrun_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (done_in) begin
            state_q <= STREAM;
            row_q   <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last) begin
              row_q <= '0;
              if (!done_in)
                state_q <= IDLE;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
      endcase
    end
  end

  // data buffer carries no reset; it is only read while streaming
  always_ff @(posedge clock) begin
    if (cap) begin
      mat_q   <= result_in;
      shift_q <= shift;
    end
  end

  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    requant_lane #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .acc  (mat_q[row_q][c]),
      .shift(shift_q),
      .q    (lane_q[c])
    );
  end

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_row   = row_q;
  assign out_last  = streaming && last;
  assign out_data  = streaming ? lane_q : '0;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: vector table plus stream sequences.
// Honours DRAIN_RELU_EN when computing expected outputs.
module tb_systolic_result_drain;

  localparam int SIZE  = 16;
  localparam int ACC_W = 20;
  localparam int OUT_W = 8;
  localparam int RW    = 4;

  logic                                 clock = 1'b0;
  logic                                 reset = 1'b1;
  logic                                 done_in = 1'b0;
  logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] result_in = '0;
  logic [4:0]                           shift = '0;
  logic                                 out_valid;
  logic                                 out_ready = 1'b0;
  logic [SIZE-1:0][OUT_W-1:0]           out_data;
  logic [RW-1:0]                        out_row;
  logic                                 out_last;
  logic                                 busy;
  logic                                 overrun;
  logic                                 clear_err = 1'b0;

  systolic_result_drain dut (
    .clock    (clock),
    .reset    (reset),
    .done_in  (done_in),
    .result_in(result_in),
    .shift    (shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun),
    .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int val;
    int sh;
    int exp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(string nm, longint act, longint exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_row(string nm, logic [SIZE*OUT_W-1:0] act,
                         logic [SIZE*OUT_W-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int relu(int v);
`ifdef DRAIN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int q(longint v, int sh);
    longint t;
    t = v;
    if (sh > 0)
      t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    if (t > 127)
      t = 127;
    if (t < -128)
      t = -128;
    return relu(int'(t));
  endfunction

  function automatic int gen(int k, int r, int c);
    case (k)
      0:       return r * 16 + c;
      1:       return 3;
      2:       return -1000;
      3:       return r * 40 - c * 37;
      default: return 0;
    endcase
  endfunction

  function automatic logic [SIZE*OUT_W-1:0] erow(int k, int r, int sh);
    logic [SIZE*OUT_W-1:0] e;
    for (int c = 0; c < SIZE; c++)
      e[c*OUT_W +: OUT_W] = OUT_W'(q(gen(k, r, c), sh));
    return e;
  endfunction

  task automatic load(int k);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        result_in[r][c] = ACC_W'(gen(k, r, c));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start(int k, int sh);
    load(k);
    shift   = 5'(sh);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    shift   = 5'd7;
  endtask

  task automatic check_row(int k, int r, int sh);
    string nm;
    nm = $sformatf("k%0d_r%0d", k, r);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_row"}, out_row, r);
    chk({nm, "_last"}, out_last, (r == SIZE - 1) ? 1 : 0);
    chk_row({nm, "_data"}, out_data, erow(k, r, sh));
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_row"}, out_row, 0);
    chk({nm, "_last"}, out_last, 0);
    chk_row({nm, "_data"}, out_data, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SIZE*OUT_W-1:0] held;
    bit pat[4];
    int er;
    int i;

    vt[0]  = '{300, 2, 75};
    vt[1]  = '{6, 2, 2};
    vt[2]  = '{-6, 2, -1};
    vt[3]  = '{524287, 0, 127};
    vt[4]  = '{-524288, 0, -128};
    vt[5]  = '{-7, 1, -3};
    vt[6]  = '{5, 1, 3};
    vt[7]  = '{1000, 3, 125};
    vt[8]  = '{1023, 3, 127};
    vt[9]  = '{-1100, 3, -128};
    vt[10] = '{524287, 19, 1};
    vt[11] = '{-524288, 19, -1};
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

    #2;
    chk_idle("reset");
    chk("reset_overrun", overrun, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // basic stream, full throughput
    out_ready = 1'b1;
    start(0, 0);
    for (int r = 0; r < SIZE; r++) begin
      check_row(0, r, 0);
      tick();
    end
    chk_idle("after_stream");

    // element requant table
    foreach (vt[k]) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++)
          result_in[r][c] = ACC_W'(vt[k].val);
      shift   = 5'(vt[k].sh);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      shift   = 5'd7;
      chk($sformatf("vec%0d_valid", k), out_valid, 1);
      chk_row($sformatf("vec%0d_data", k), out_data,
              {SIZE{OUT_W'(relu(vt[k].exp))}});
      repeat (SIZE) tick();
      chk($sformatf("vec%0d_idle", k), out_valid, 0);
    end

    // backpressure 1,0,0,1
    start(3, 2);
    er = 0;
    i  = 0;
    held = out_data;
    while (er < SIZE && i < 100) begin
      out_ready = pat[i % 4];
      check_row(3, er, 2);
      chk_row($sformatf("stall_hold%0d", i), out_data, held);
      tick();
      if (pat[i % 4])
        er++;
      held = out_data;
      i++;
    end
    chk("stall_rows", er, SIZE);
    out_ready = 1'b1;
    chk("stall_idle", out_valid, 0);

    // overrun, back-to-back, clear
    start(0, 0);
    chk("ovr_init", overrun, 0);
    for (int r = 0; r < SIZE; r++) begin
      check_row(0, r, 0);
      if (r == 5) begin
        load(2);
        done_in = 1'b1;
      end
      if (r == SIZE - 1) begin
        load(1);
        shift   = 5'd0;
        done_in = 1'b1;
      end
      tick();
      done_in = 1'b0;
      shift   = 5'd7;
      if (r == 5)
        chk("ovr_set", overrun, 1);
    end
    check_row(1, 0, 0);
    chk("ovr_held", overrun, 1);
    clear_err = 1'b1;
    done_in   = 1'b1;
    tick();
    clear_err = 1'b0;
    done_in   = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    check_row(1, 1, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovr_clear", overrun, 0);
    for (int r = 2; r < SIZE; r++) begin
      check_row(1, r, 0);
      tick();
    end
    chk_idle("b2b_idle");

    // reset mid-stream
    start(0, 0);
    repeat (7) tick();
    check_row(0, 7, 0);
    reset = 1'b1;
    #1;
    chk_idle("rst_mid");
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_quiet%0d", k), out_valid, 0);
    end
    start(1, 0);
    check_row(1, 0, 0);
    repeat (SIZE) tick();
    chk("rst_final_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter SIZE, default 16, array dimension (rows and lanes).
REQ-002 Parameter ACC_W, default 20, signed accumulator width of incoming results.
REQ-003 Parameter OUT_W, default 8, signed output element width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 done_in  input  1  one-cycle pulse from the upstream array: result_in is valid this cycle.
REQ-007 result_in  input  SIZE x SIZE x ACC_W signed  accumulator matrix [row][col].
REQ-008 shift  input  5  requantization right-shift amount, 0..ACC_W-1.
REQ-009 out_valid  output  1  out_data holds a valid row.
REQ-010 out_ready  input  1  downstream accepts the row when out_valid and out_ready are both high.
REQ-011 out_data  output  SIZE x OUT_W signed  requantized row, lane c = column c.
REQ-012 out_row  output  $clog2(SIZE)  index of the row on out_data.
REQ-013 out_last  output  1  high with out_valid on row SIZE-1.
REQ-014 busy  output  1  high while a matrix is held or streaming.
REQ-015 overrun  output  1  sticky flag: done_in arrived while busy and was dropped.
REQ-016 clear_err  input  1  synchronous clear of overrun.

Function
REQ-017 FSM states: IDLE and STREAM only.
REQ-018 IDLE with done_in: capture result_in and shift into internal buffers, enter STREAM, row=0.
REQ-019 Latency: done_in in cycle N gives out_valid=1 with row 0 in cycle N+1.
REQ-020 STREAM: out_valid=1 and busy=1; out_data/out_row/out_last are stable until accepted.
REQ-021 Acceptance of row r<SIZE-1 advances to r+1 next cycle; no out_valid bubble between rows.
REQ-022 Acceptance of row SIZE-1 returns to IDLE, except as in REQ-023.
REQ-023 done_in in the same cycle as acceptance of row SIZE-1 is captured; STREAM restarts at row 0 next cycle, giving back-to-back matrices.
REQ-024 done_in in any other STREAM cycle is dropped, sets overrun, and leaves the buffer untouched.
REQ-025 If clear_err and a setting event occur in the same cycle, set wins.
REQ-026 Requantization per element: if shift>0, add 2^(shift-1) (round half up); then arithmetic right shift by shift; then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 Rounding addition is done in ACC_W+1 bits so that no intermediate overflow occurs.
REQ-028 Requantization uses the shift value captured with the matrix, not the live input.
REQ-029 IDLE outputs: out_valid=0, out_data=0, out_row=0, out_last=0, busy=0.

Reset
REQ-030 reset asserted: state=IDLE; all outputs go to their REQ-029 values; overrun=0. Data buffers need no reset.
REQ-031 Reset during STREAM abandons the matrix; the first valid row after reset requires a new done_in.

Configuration
REQ-032 Macro DRAIN_RELU_EN defined: each element is clamped to 0 if negative after saturation.
REQ-033 DRAIN_RELU_EN undefined: plain signed saturation with no ReLU; the interface is identical in both cases.

Structure
REQ-034 Package drain_pkg holds the state enum and the default SIZE/ACC_W/OUT_W localparams.
REQ-035 Sub-module requant_lane is one combinational rounding/shift/saturate/ReLU lane, instantiated SIZE times.

Verification
REQ-036 result[r][c]=r*16+c, shift=0, out_ready=1 -> rows 0..15 on 16 consecutive cycles, starting 1 cycle after done_in; out_last only on row 15.
REQ-037 Element 300, shift=2 -> 75; element 6, shift=2 -> 2 (6+2=8, 8>>2); element -6, shift=2 -> -1 (-6+2=-4, -4>>2).
REQ-038 Elements 524287 and -524288, shift=0 -> 127 and -128; with DRAIN_RELU_EN -> 127 and 0.
REQ-039 out_ready toggles 1,0,0,1 -> out_data and out_row hold stable during stall cycles; all 16 rows are delivered in order.
REQ-040 done_in at row 5 -> overrun=1 and stream unaffected; done_in with acceptance of row 15 -> row 0 of new matrix next cycle; clear_err -> overrun=0.
REQ-041 reset asserted at row 7 -> out_valid=0 immediately, state IDLE, no further rows until a new done_in.
